alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and issue sequencer for the shared combinational `alu` block. It accepts operations from two clients over valid/ready handshakes and selects one per cycle, by round-robin or fixed priority. It registers the winning operation into an issue stage that drives the ALU, then captures the ALU result and returns it to the originating client with fixed latency. It sits between client logic and a single `alu` instance, making the ALU's `en_i`, `ctl_i` and `AB_i` drive single-sourced.

## Interface
Parameters:
- `WIDTH`, default 8, operand width; must match the attached `alu` instance.

Ports:
- `clk_i`  input  1  sole clock; all state updates on its rising edge.
- `rst_i`  input  1  reset; synchronous, active-high.
- `req0_valid_i`  input  1  client 0 has an operation pending.
- `req0_ready_o`  output  1  client 0 operation accepted this edge.
- `req0_ctl_i`  input  3  client 0 ALU opcode.
- `req0_ab_i`  input  2*WIDTH  client 0 operands {A, B}.
- `req1_valid_i`, `req1_ready_o`, `req1_ctl_i`, `req1_ab_i`: client 1 equivalents, same widths.
- `rsp0_valid_o`  output  1  one-cycle strobe; `rsp0_bc_o` is valid.
- `rsp0_bc_o`  output  2*WIDTH  {B, C} result for client 0.
- `rsp1_valid_o`, `rsp1_bc_o`: client 1 equivalents.
- `alu_en_o`  output  1  to ALU `en_i`; high while the issue stage holds a valid operation.
- `alu_ctl_o`  output  3  to ALU `ctl_i`.
- `alu_ab_o`  output  2*WIDTH  to ALU `AB_i`.
- `alu_bc_i`  input  2*WIDTH  from ALU `BC_o`.

## Operation
- Handshake: a transfer occurs on a rising edge where `reqN_valid_i && reqN_ready_o`. The client holds `ctl`/`ab` stable while valid and not yet accepted.
- Ready is combinational from the valids and the priority pointer. At most one ready is high per cycle. Both readys are 0 while `rst_i` is high.
- Grant rules:
  - Only one client valid: that client is granted regardless of the pointer.
  - Both valid: the client indicated by `ptr` is granted.
  - Neither valid: no grant and no issue.
- Pointer (`ALU_ARB_RR_EN` defined): 1-bit `ptr`, reset 0 (client 0 favored). After any grant, `ptr` points to the non-granted client.
- Issue stage: registers {valid, tag, ctl, ab} on the accept edge. `alu_en_o` = issue valid. `alu_ctl_o`/`alu_ab_o` = registered values, and are 0 when issue is not valid.
- Response stage: on the edge following issue, `alu_bc_i` is latched into `rspTAG_bc_o` and `rspTAG_valid_o` pulses high for one cycle. The other client's valid stays 0.
- `rspN_bc_o` holds its last value until overwritten. There is no response backpressure; clients must always accept responses.
- Arithmetic is performed by the ALU and is modulo 2^WIDTH. This block never alters the result.

## Timing
- Latency: operation accepted at edge E0 → `alu_en_o`=1 during E0..E1 → `rspN_valid_o`=1 during E1..E2. Two cycles from accept to response.
- Throughput: one accepted operation per cycle. Back-to-back operations from alternating or the same client are fully pipelined.
- Simultaneous valid with round-robin: grants alternate 0,1,0,1… every cycle.
- Reset values (after any edge with `rst_i`=1): all `*_valid_o`, `*_ready_o` and `alu_en_o` are 0. `alu_ctl_o`, `alu_ab_o` and `rsp*_bc_o` are 0. `ptr` is 0.
- Reset mid-operation: issue and response stages are flushed. Operations accepted before reset produce no response.
- A valid dropped before acceptance is legal and is simply not granted.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration using `ptr` as above.
- `ALU_ARB_RR_EN` undefined: fixed priority, client 0 always wins when both are valid, and `ptr` is not implemented. Client 1 may starve under continuous client-0 traffic. All other behaviour and timing is identical.

## Test plan
- Reset: hold `rst_i`=1 for 3 cycles with both valids high → all outputs 0. After release, client 0 is granted first.
- Single add: client 0, ctl=3'b100, ab={8'hF0,8'h20} → `alu_en_o`=1 one cycle after accept, then `rsp0_valid_o` pulse with `rsp0_bc_o`={8'h20,8'h10}. `rsp1_valid_o` stays 0.
- Contention (RR): both clients valid for 4 cycles, client 0 sub {05,07}, client 1 OR {0F,F0} → grants 0,1,0,1; `rsp0_bc_o`={07,FE}; `rsp1_bc_o`={F0,FF}. Each response arrives 2 cycles after its accept.
- Contention (macro undefined): both valid for 4 cycles → client 0 granted every cycle and `req1_ready_o` stays 0.
- Reset mid-flight: accept a client 1 op, assert `rst_i` on the next edge → no `rsp1_valid_o` pulse, and `alu_en_o`=0.
- Constants: ctl=000 and ctl=001 with ab={AA,55} → C=00 and C=01 respectively, with B=55 passed through.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-client arbiter and two-stage issue/response sequencer for a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise client 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [2:0]         req0_ctl_i,
  input  logic [2*WIDTH-1:0] req0_ab_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [2:0]         req1_ctl_i,
  input  logic [2*WIDTH-1:0] req1_ab_i,
  output logic               rsp0_valid_o,
  output logic [2*WIDTH-1:0] rsp0_bc_o,
  output logic               rsp1_valid_o,
  output logic [2*WIDTH-1:0] rsp1_bc_o,
  output logic               alu_en_o,
  output logic [2:0]         alu_ctl_o,
  output logic [2*WIDTH-1:0] alu_ab_o,
  input  logic [2*WIDTH-1:0] alu_bc_i
);

  logic               w_ptr;
  logic               w_gnt0;
  logic               w_gnt1;

  logic               r_iss_valid;
  logic               r_iss_tag;
  logic [2:0]         r_iss_ctl;
  logic [2*WIDTH-1:0] r_iss_ab;

  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [2*WIDTH-1:0] r_rsp0_bc;
  logic [2*WIDTH-1:0] r_rsp1_bc;

`ifdef ALU_ARB_RR_EN
  logic r_ptr;

  // After a grant the pointer favours the client that lost (or did not ask).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_ptr <= w_gnt0;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_comb begin
    w_gnt0 = !rst_i && req0_valid_i && (!req1_valid_i || !w_ptr);
    w_gnt1 = !rst_i && req1_valid_i && (!req0_valid_i || w_ptr);
  end

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;

  // Issue registers are cleared when idle so the ALU drive is 0 without gating.
  always_ff @(posedge clk_i) begin
    if (rst_i || !(w_gnt0 || w_gnt1)) begin
      r_iss_valid <= 1'b0;
      r_iss_tag   <= 1'b0;
      r_iss_ctl   <= '0;
      r_iss_ab    <= '0;
    end else begin
      r_iss_valid <= 1'b1;
      r_iss_tag   <= w_gnt1;
      r_iss_ctl   <= w_gnt1 ? req1_ctl_i : req0_ctl_i;
      r_iss_ab    <= w_gnt1 ? req1_ab_i : req0_ab_i;
    end
  end

  assign alu_en_o  = r_iss_valid;
  assign alu_ctl_o = r_iss_ctl;
  assign alu_ab_o  = r_iss_ab;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_bc    <= '0;
      r_rsp1_bc    <= '0;
    end else begin
      r_rsp0_valid <= r_iss_valid && !r_iss_tag;
      r_rsp1_valid <= r_iss_valid && r_iss_tag;
      if (r_iss_valid && !r_iss_tag) begin
        r_rsp0_bc <= alu_bc_i;
      end
      if (r_iss_valid && r_iss_tag) begin
        r_rsp1_bc <= alu_bc_i;
      end
    end
  end

  assign rsp0_valid_o = r_rsp0_valid;
  assign rsp1_valid_o = r_rsp1_valid;
  assign rsp0_bc_o    = r_rsp0_bc;
  assign rsp1_bc_o    = r_rsp1_bc;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stand-in ALU; expectations follow ALU_ARB_RR_EN.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               req0_valid_i, req1_valid_i;
  logic               req0_ready_o, req1_ready_o;
  logic [2:0]         req0_ctl_i, req1_ctl_i;
  logic [2*WIDTH-1:0] req0_ab_i, req1_ab_i;
  logic               rsp0_valid_o, rsp1_valid_o;
  logic [2*WIDTH-1:0] rsp0_bc_o, rsp1_bc_o;
  logic               alu_en_o;
  logic [2:0]         alu_ctl_o;
  logic [2*WIDTH-1:0] alu_ab_o;
  logic [2*WIDTH-1:0] alu_bc_i;

  int total = 0;
  int bad   = 0;

`ifdef ALU_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_ctl_i   (req0_ctl_i),
    .req0_ab_i    (req0_ab_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_ctl_i   (req1_ctl_i),
    .req1_ab_i    (req1_ab_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_bc_o    (rsp0_bc_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_bc_o    (rsp1_bc_o),
    .alu_en_o     (alu_en_o),
    .alu_ctl_o    (alu_ctl_o),
    .alu_ab_o     (alu_ab_o),
    .alu_bc_i     (alu_bc_i)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in ALU: BC = {B, C}; opcodes 100 add, 101 sub (A-B), 110 or.
  always_comb begin
    logic [WIDTH-1:0] a, b, c;
    a = alu_ab_o[2*WIDTH-1:WIDTH];
    b = alu_ab_o[WIDTH-1:0];
    case (alu_ctl_o)
      3'b000:  c = '0;
      3'b001:  c = 8'h01;
      3'b100:  c = a + b;
      3'b101:  c = a - b;
      3'b110:  c = a | b;
      default: c = '0;
    endcase
    alu_bc_i = {b, c};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic exp_g;
    logic prev_g;

    rst_i = 1'b1;
    req0_valid_i = 1'b1; req0_ctl_i = 3'b100; req0_ab_i = 16'hF020;
    req1_valid_i = 1'b1; req1_ctl_i = 3'b110; req1_ab_i = 16'h0FF0;

    // Reset held with both clients requesting.
    repeat (3) step();
    check("rst_ready0", 32'(req0_ready_o), 32'd0);
    check("rst_ready1", 32'(req1_ready_o), 32'd0);
    check("rst_alu_en", 32'(alu_en_o), 32'd0);
    check("rst_alu_ctl", 32'(alu_ctl_o), 32'd0);
    check("rst_alu_ab", 32'(alu_ab_o), 32'd0);
    check("rst_rsp0_v", 32'(rsp0_valid_o), 32'd0);
    check("rst_rsp1_v", 32'(rsp1_valid_o), 32'd0);
    check("rst_rsp0_bc", 32'(rsp0_bc_o), 32'd0);
    check("rst_rsp1_bc", 32'(rsp1_bc_o), 32'd0);

    rst_i = 1'b0;
    #1;
    check("first_ready0", 32'(req0_ready_o), 32'd1);
    check("first_ready1", 32'(req1_ready_o), 32'd0);

    // Single add from client 0.
    req1_valid_i = 1'b0;
    #1;
    step();
    req0_valid_i = 1'b0;
    #1;
    check("add_en", 32'(alu_en_o), 32'd1);
    check("add_ctl", 32'(alu_ctl_o), 32'h4);
    check("add_ab", 32'(alu_ab_o), 32'hF020);
    check("add_rsp0_early", 32'(rsp0_valid_o), 32'd0);
    step();
    check("add_rsp0_v", 32'(rsp0_valid_o), 32'd1);
    check("add_rsp0_bc", 32'(rsp0_bc_o), 32'h2010);
    check("add_rsp1_v", 32'(rsp1_valid_o), 32'd0);
    check("add_en_off", 32'(alu_en_o), 32'd0);
    check("add_ctl_off", 32'(alu_ctl_o), 32'd0);
    step();
    check("add_rsp0_pulse", 32'(rsp0_valid_o), 32'd0);
    check("add_rsp0_hold", 32'(rsp0_bc_o), 32'h2010);

    // Client 1 accepted, then reset on the following edge.
    req1_valid_i = 1'b1; req1_ctl_i = 3'b110; req1_ab_i = 16'h0FF0;
    #1;
    check("mid_ready1", 32'(req1_ready_o), 32'd1);
    step();
    req1_valid_i = 1'b0;
    check("mid_en", 32'(alu_en_o), 32'd1);
    rst_i = 1'b1;
    step();
    check("mid_rsp1_v", 32'(rsp1_valid_o), 32'd0);
    check("mid_en_off", 32'(alu_en_o), 32'd0);
    check("mid_rsp0_bc", 32'(rsp0_bc_o), 32'd0);
    rst_i = 1'b0;
    step();
    check("mid_rsp1_v2", 32'(rsp1_valid_o), 32'd0);
    check("mid_rsp1_bc", 32'(rsp1_bc_o), 32'd0);

    // Contention: client 0 sub {05,07}, client 1 or {0F,F0}, both valid 4 cycles.
    req0_valid_i = 1'b1; req0_ctl_i = 3'b101; req0_ab_i = 16'h0507;
    req1_valid_i = 1'b1; req1_ctl_i = 3'b110; req1_ab_i = 16'h0FF0;
    prev_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_g = RrEn ? i[0] : 1'b0;
      #1;
      check($sformatf("con_ready0_%0d", i), 32'(req0_ready_o), 32'(!exp_g));
      check($sformatf("con_ready1_%0d", i), 32'(req1_ready_o), 32'(exp_g));
      step();
      check($sformatf("con_en_%0d", i), 32'(alu_en_o), 32'd1);
      check($sformatf("con_ctl_%0d", i), 32'(alu_ctl_o), exp_g ? 32'h6 : 32'h5);
      if (i > 0) begin
        check($sformatf("con_rsp0_v_%0d", i), 32'(rsp0_valid_o), 32'(!prev_g));
        check($sformatf("con_rsp1_v_%0d", i), 32'(rsp1_valid_o), 32'(prev_g));
      end
      prev_g = exp_g;
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    step();
    check("con_rsp0_v_last", 32'(rsp0_valid_o), 32'(!prev_g));
    check("con_rsp1_v_last", 32'(rsp1_valid_o), 32'(prev_g));
    check("con_rsp0_bc", 32'(rsp0_bc_o), 32'h07FE);
    check("con_rsp1_bc", 32'(rsp1_bc_o), RrEn ? 32'hF0FF : 32'h0);
    check("con_en_off", 32'(alu_en_o), 32'd0);
    step();
    check("con_idle_rsp0", 32'(rsp0_valid_o), 32'd0);
    check("con_idle_rsp1", 32'(rsp1_valid_o), 32'd0);

    // Constant opcodes back to back from client 1.
    req1_valid_i = 1'b1; req1_ctl_i = 3'b000; req1_ab_i = 16'hAA55;
    step();
    req1_ctl_i = 3'b001;
    step();
    req1_valid_i = 1'b0;
    check("const_en", 32'(alu_en_o), 32'd1);
    check("const_rsp1_v0", 32'(rsp1_valid_o), 32'd1);
    check("const_c00", 32'(rsp1_bc_o), 32'h5500);
    step();
    check("const_rsp1_v1", 32'(rsp1_valid_o), 32'd1);
    check("const_c01", 32'(rsp1_bc_o), 32'h5501);
    check("const_rsp0_quiet", 32'(rsp0_valid_o), 32'd0);
    step();
    check("const_rsp1_done", 32'(rsp1_valid_o), 32'd0);
    check("const_hold", 32'(rsp1_bc_o), 32'h5501);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
